// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: control decode, 32-bit datapath, PC adders and a
// registered zero flag that balrz instructions consume one instruction later.
module exec_alu_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  aluop,
   input  logic [5:0]  funct,
   input  logic        bltz,
   input  logic        balrz,
   input  logic        sllv,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic [31:0] pc,
   input  logic [31:0] offset,
   output logic [2:0]  alu_ctl,
   output logic [31:0] result,
   output logic        zero,
   output logic        neg,
   output logic [31:0] pc_plus4,
   output logic [31:0] br_target,
   output logic        status
);

   logic [2:0] funct_ctl;
   logic       status_d, status_q;

   always_comb begin
      funct_ctl = 3'b010;
      case (funct)
         6'b100000: funct_ctl = 3'b010;
         6'b100010: funct_ctl = 3'b110;
         6'b100100: funct_ctl = 3'b000;
         6'b100101: funct_ctl = 3'b001;
         6'b101010: funct_ctl = 3'b111;
         6'b000100: funct_ctl = 3'b011;
         default:   funct_ctl = 3'b010;
      endcase
   end

   // Instruction flags override the main decoder's operation class.
   always_comb begin
      alu_ctl = 3'b010;
      if (bltz)       alu_ctl = 3'b110;
      else if (balrz) alu_ctl = 3'b010;
      else if (sllv)  alu_ctl = 3'b011;
      else begin
         case (aluop)
            2'b00:   alu_ctl = 3'b010;
            2'b01:   alu_ctl = 3'b110;
            2'b11:   alu_ctl = 3'b001;
            default: alu_ctl = funct_ctl;
         endcase
      end
   end

   always_comb begin
      result = 32'h0;
      case (alu_ctl)
         3'b000:  result = opa & opb;
         3'b001:  result = opa | opb;
         3'b010:  result = opa + opb;
         3'b110:  result = opa - opb;
         3'b111:  result = {31'h0, $signed(opa) < $signed(opb)};
         3'b011:  result = opb << opa[4:0];
         default: result = 32'h0;
      endcase
   end

   assign zero      = (result == 32'h0);
   assign neg       = result[31];
   assign pc_plus4  = pc + 32'h4;
   assign br_target = pc_plus4 + offset;

   // balrz freezes the flag so it still reflects the preceding instruction.
   always_comb begin
      status_d = balrz ? status_q : zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) status_q <= 1'b0;
      else        status_q <= status_d;
   end

   assign status = status_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Bench for exec_alu_unit: directed vector table, status sequences and
// randomized stimulus against a behavioural reference.
module tb_exec_alu_unit;

   logic        clk, rst_n;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic        bltz, balrz, sllv;
   logic [31:0] opa, opb, pc, offset;
   logic [2:0]  alu_ctl;
   logic [31:0] result;
   logic        zero, neg;
   logic [31:0] pc_plus4, br_target;
   logic        status;

   int n_tests = 0;
   int n_fail  = 0;
   logic m_status;

   exec_alu_unit dut (
      .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct),
      .bltz(bltz), .balrz(balrz), .sllv(sllv), .opa(opa), .opb(opb),
      .pc(pc), .offset(offset), .alu_ctl(alu_ctl), .result(result),
      .zero(zero), .neg(neg), .pc_plus4(pc_plus4), .br_target(br_target),
      .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic        bltz, balrz, sllv;
      logic [31:0] opa, opb, pc, offset;
      logic [2:0]  e_ctl;
      logic [31:0] e_res;
      logic        e_zero, e_neg;
      logic [31:0] e_p4, e_bt;
   } vec_t;

   vec_t vt[17];

   function automatic logic [2:0] ref_ctl(logic [1:0] ao, logic [5:0] fn,
                                          logic bz, logic br, logic sv);
      if (bz) return 3'b110;
      if (br) return 3'b010;
      if (sv) return 3'b011;
      if (ao == 2'b00) return 3'b010;
      if (ao == 2'b01) return 3'b110;
      if (ao == 2'b11) return 3'b001;
      if (fn == 6'h20) return 3'b010;
      if (fn == 6'h22) return 3'b110;
      if (fn == 6'h24) return 3'b000;
      if (fn == 6'h25) return 3'b001;
      if (fn == 6'h2A) return 3'b111;
      if (fn == 6'h04) return 3'b011;
      return 3'b010;
   endfunction

   function automatic logic [31:0] ref_res(logic [2:0] c, logic [31:0] a, logic [31:0] b);
      longint sa, sb;
      longint unsigned p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         3'b110: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
         3'b111: return (sa < sb) ? 32'h1 : 32'h0;
         3'b011: begin
            p = 64'(b) * (64'h1 << a[4:0]);
            return 32'(p % 64'h1_0000_0000);
         end
         default: return 32'h0;
      endcase
   endfunction

   // Status reference: zero flag of the current instruction unless balrz.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_status <= 1'b0;
      else if (!balrz)
         m_status <= (ref_res(ref_ctl(aluop, funct, bltz, balrz, sllv), opa, opb) == 32'h0);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      aluop = v.aluop; funct = v.funct; bltz = v.bltz; balrz = v.balrz;
      sllv = v.sllv; opa = v.opa; opb = v.opb; pc = v.pc; offset = v.offset;
   endtask

   function automatic vec_t mk(logic [1:0] ao, logic [5:0] fn, logic bz, logic br,
                               logic sv, logic [31:0] a, logic [31:0] b,
                               logic [31:0] p, logic [31:0] o, logic [2:0] c,
                               logic [31:0] r, logic z, logic n,
                               logic [31:0] p4, logic [31:0] bt);
      vec_t v;
      v.aluop = ao; v.funct = fn; v.bltz = bz; v.balrz = br; v.sllv = sv;
      v.opa = a; v.opb = b; v.pc = p; v.offset = o; v.e_ctl = c; v.e_res = r;
      v.e_zero = z; v.e_neg = n; v.e_p4 = p4; v.e_bt = bt;
      return v;
   endfunction

   initial begin
      vt[0]  = mk(2'b10, 6'h20, 0,0,0, 32'd7, 32'd5, 32'h1C, 32'hFFFFFFF0, 3'b010, 32'd12, 0,0, 32'h20, 32'h10);
      vt[1]  = mk(2'b10, 6'h2A, 0,0,0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFC, 32'h0, 3'b111, 32'h1, 0,0, 32'h0, 32'h0);
      vt[2]  = mk(2'b10, 6'h2A, 0,0,0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h8, 3'b111, 32'h0, 1,0, 32'h4, 32'hC);
      vt[3]  = mk(2'b00, 6'h00, 1,0,0, 32'hFFFFFFF8, 32'h0, 32'h100, 32'h4, 3'b110, 32'hFFFFFFF8, 0,1, 32'h104, 32'h108);
      vt[4]  = mk(2'b00, 6'h00, 1,0,0, 32'h3, 32'h0, 32'h0, 32'h0, 3'b110, 32'h3, 0,0, 32'h4, 32'h4);
      vt[5]  = mk(2'b00, 6'h00, 0,0,1, 32'h4, 32'h3, 32'h0, 32'h0, 3'b011, 32'h30, 0,0, 32'h4, 32'h4);
      vt[6]  = mk(2'b00, 6'h00, 0,0,1, 32'h24, 32'h3, 32'h0, 32'h0, 3'b011, 32'h30, 0,0, 32'h4, 32'h4);
      vt[7]  = mk(2'b10, 6'h22, 0,0,0, 32'd5, 32'd7, 32'h0, 32'h0, 3'b110, 32'hFFFFFFFE, 0,1, 32'h4, 32'h4);
      vt[8]  = mk(2'b10, 6'h24, 0,0,0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 3'b000, 32'hF000, 0,0, 32'h4, 32'h4);
      vt[9]  = mk(2'b10, 6'h25, 0,0,0, 32'hF0F0, 32'h0F0F, 32'h0, 32'h0, 3'b001, 32'hFFFF, 0,0, 32'h4, 32'h4);
      vt[10] = mk(2'b10, 6'h04, 0,0,0, 32'h8, 32'h1, 32'h0, 32'h0, 3'b011, 32'h100, 0,0, 32'h4, 32'h4);
      vt[11] = mk(2'b10, 6'h3F, 0,0,0, 32'h1, 32'h2, 32'h0, 32'h0, 3'b010, 32'h3, 0,0, 32'h4, 32'h4);
      vt[12] = mk(2'b11, 6'h20, 0,0,0, 32'hA, 32'h5, 32'h0, 32'h0, 3'b001, 32'hF, 0,0, 32'h4, 32'h4);
      vt[13] = mk(2'b01, 6'h20, 0,0,0, 32'h9, 32'h9, 32'h0, 32'h0, 3'b110, 32'h0, 1,0, 32'h4, 32'h4);
      vt[14] = mk(2'b00, 6'h22, 0,0,0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 3'b010, 32'h0, 1,0, 32'h4, 32'h4);
      vt[15] = mk(2'b11, 6'h24, 1,1,1, 32'h1, 32'h1, 32'h0, 32'h0, 3'b110, 32'h0, 1,0, 32'h4, 32'h4);
      vt[16] = mk(2'b11, 6'h24, 0,1,1, 32'h2, 32'h3, 32'h0, 32'h0, 3'b010, 32'h5, 0,0, 32'h4, 32'h4);

      rst_n = 1'b0;
      drive(vt[13]);
      #1;
      chk("reset_status", 32'(status), 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("status_held_in_reset", 32'(status), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         chk($sformatf("v%0d_ctl", i), 32'(alu_ctl), 32'(vt[i].e_ctl));
         chk($sformatf("v%0d_res", i), result, vt[i].e_res);
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vt[i].e_zero));
         chk($sformatf("v%0d_neg", i), 32'(neg), 32'(vt[i].e_neg));
         chk($sformatf("v%0d_p4", i), pc_plus4, vt[i].e_p4);
         chk($sformatf("v%0d_bt", i), br_target, vt[i].e_bt);
      end

      // Status sequence: compare sets flag, balrz holds it, reset clears it.
      @(negedge clk);
      drive(mk(2'b01, 6'h0, 0,0,0, 32'd9, 32'd9, 32'h0, 32'h0, 3'b0, 32'h0, 0,0, 32'h0, 32'h0));
      @(posedge clk); #1;
      chk("seq_status_set", 32'(status), 32'h1);
      @(negedge clk);
      balrz = 1'b1; opa = 32'd5;
      #1;
      chk("seq_balrz_zero_low", 32'(zero), 32'h0);
      @(posedge clk); #1;
      chk("seq_status_hold", 32'(status), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("seq_async_reset", 32'(status), 32'h0);
      chk("seq_comb_in_reset", result, 32'd14);
      @(posedge clk); #1;
      chk("seq_reset_holds", 32'(status), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      balrz = 1'b0; aluop = 2'b01; opa = 32'd3; opb = 32'd3;
      @(posedge clk); #1;
      chk("seq_first_edge", 32'(status), 32'h1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic [2:0] ec;
         logic [31:0] er;
         @(negedge clk);
         chk($sformatf("rnd%0d_status", i), 32'(status), 32'(m_status));
         aluop = 2'($urandom); funct = 6'($urandom);
         if ($urandom_range(0, 1) == 1) funct = 6'(($urandom_range(0, 5) == 5) ? 6'h04 : 6'h20 + 6'($urandom_range(0, 10)));
         bltz  = ($urandom_range(0, 9) == 0);
         balrz = ($urandom_range(0, 5) == 0);
         sllv  = ($urandom_range(0, 9) == 0);
         opa = $urandom; opb = $urandom;
         if ($urandom_range(0, 3) == 0) opb = opa;
         if ($urandom_range(0, 7) == 0) opa = 32'h0;
         pc = $urandom; offset = $urandom;
         #1;
         ec = ref_ctl(aluop, funct, bltz, balrz, sllv);
         er = ref_res(ec, opa, opb);
         chk($sformatf("rnd%0d_ctl", i), 32'(alu_ctl), 32'(ec));
         chk($sformatf("rnd%0d_res", i), result, er);
         chk($sformatf("rnd%0d_zero", i), 32'(zero), 32'(er == 32'h0));
         chk($sformatf("rnd%0d_neg", i), 32'(neg), 32'(er[31]));
         chk($sformatf("rnd%0d_p4", i), pc_plus4, 32'((64'(pc) + 64'd4) % 64'h1_0000_0000));
         chk($sformatf("rnd%0d_bt", i), br_target,
             32'((64'(pc) + 64'd4 + 64'(offset)) % 64'h1_0000_0000));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
